multdiv_wb_arbiter: RTL and testbench

- Sits directly downstream of the multiply/divide control block. Consumes its result, exception flag, ready pulse and latched instruction.
- Buffers completed results in a small FIFO and merges them onto the single register-file write port, yielding to the normal MW-stage writeback.
- Exports an issue stall and a per-register busy mask so the hazard unit blocks dependent instructions and new mult/div issue.

---
 rtl/multdiv_wb_pkg.sv | 21 ++
 rtl/multdiv_wb_fifo.sv | 70 +++++++
 rtl/multdiv_wb_arbiter.sv | 156 +++++++++++++++
 tb/tb_multdiv_wb_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_wb_pkg.sv
// Shared definitions for the mult/div writeback arbiter: instruction field
// positions, opcodes, exception codes and the buffered writeback entry.
package multdiv_wb_pkg;

  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;

  localparam logic [31:0] EXC_MUL = 32'd4;
  localparam logic [31:0] EXC_DIV = 32'd5;

  localparam int unsigned RD_HI = 26;
  localparam int unsigned RD_LO = 22;
  localparam int unsigned OP_HI = 6;
  localparam int unsigned OP_LO = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/multdiv_wb_fifo.sv
// Circular buffer of completed mult/div results. Exposes the count and each
// slot's valid/rd so the arbiter can build the busy mask.
module multdiv_wb_fifo
  import multdiv_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  wb_entry_t                    entry_i,
  input  logic                         pop_i,
  output wb_entry_t                    head_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [DEPTH-1:0]             valid_o,
  output logic [4:0]                   rd_o [DEPTH]
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t        mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             full, pop_eff, push_eff;

  assign empty_o  = (count_q == '0);
  assign full     = (count_q == CntW'(DEPTH));
  assign pop_eff  = pop_i & ~empty_o;
  // A slot freed by a same-cycle pop may be refilled.
  assign push_eff = push_i & (~full | pop_eff);

  // Slot occupancy: pop frees the head slot, push claims the tail slot.
  always_comb begin
    valid_d = valid_q;
    if (pop_eff)  valid_d[rptr_q] = 1'b0;
    if (push_eff) valid_d[wptr_q] = 1'b1;
  end

  // Pointer, count and storage update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_eff) begin
        mem_q[wptr_q] <= entry_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop_eff) rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CntW'(push_eff) - CntW'(pop_eff);
      valid_q <= valid_d;
    end
  end

  // Per-slot destination visibility.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) rd_o[i] = mem_q[i].rd;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/multdiv_wb_arbiter.sv
// Merges mult/div completions onto the single register-file write port behind
// the MW-stage writeback, and exports issue stall and register busy mask.
// Optional macro MULTDIV_WB_BYPASS_EN: a completion that finds the FIFO empty
// and the port free is written in the same cycle instead of being buffered.
module multdiv_wb_arbiter
  import multdiv_wb_pkg::*;
#(
  parameter int unsigned DEPTH       = 2,
  parameter logic [4:0]  RSTATUS_REG = 5'd30
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        md_start,
  input  logic [31:0] md_start_ir,
  input  logic        md_ready,
  input  logic        md_x,
  input  logic [31:0] md_res,
  input  logic        mw_we,
  input  logic [4:0]  mw_rd,
  input  logic [31:0] mw_data,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  output logic        issue_stall,
  output logic [31:0] busy_mask
);

  localparam int unsigned    CntW       = $clog2(DEPTH + 1);
  // One slot is always kept free for the result still in flight.
  localparam logic [CntW-1:0] StallCount = CntW'(DEPTH - 1);

  logic       inflight_valid_q, inflight_valid_d;
  logic [4:0] inflight_rd_q, inflight_rd_d;
  logic [4:0] inflight_op_q, inflight_op_d;

  logic       complete, done_keep, mw_claim, bypass_ok, bypass;
  wb_entry_t  done_entry, fifo_head;
  logic       fifo_push, fifo_pop, fifo_empty;
  logic [CntW-1:0]  fifo_count;
  logic [DEPTH-1:0] fifo_valid;
  logic [4:0]       fifo_rd [DEPTH];

  logic unused_ir;
  assign unused_ir = ^{md_start_ir[31:RD_HI+1], md_start_ir[RD_LO-1:OP_HI+1],
                       md_start_ir[OP_LO-1:0]};

  assign complete = md_ready & inflight_valid_q;
  assign mw_claim = mw_we & (mw_rd != 5'd0);

  // Track the single outstanding operation; a start while busy is dropped.
  always_comb begin
    inflight_valid_d = inflight_valid_q;
    inflight_rd_d    = inflight_rd_q;
    inflight_op_d    = inflight_op_q;
    if (complete) begin
      inflight_valid_d = 1'b0;
    end else if (md_start && !inflight_valid_q) begin
      inflight_valid_d = 1'b1;
      inflight_rd_d    = md_start_ir[RD_HI:RD_LO];
      inflight_op_d    = md_start_ir[OP_HI:OP_LO];
    end
  end

  // In-flight state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_valid_q <= 1'b0;
      inflight_rd_q    <= 5'd0;
      inflight_op_q    <= 5'd0;
    end else begin
      inflight_valid_q <= inflight_valid_d;
      inflight_rd_q    <= inflight_rd_d;
      inflight_op_q    <= inflight_op_d;
    end
  end

  // Build the writeback entry; exceptions redirect to the status register.
  always_comb begin
    done_entry.rd   = inflight_rd_q;
    done_entry.data = md_res;
    if (md_x) begin
      done_entry.rd   = RSTATUS_REG;
      done_entry.data = (inflight_op_q == OP_DIV) ? EXC_DIV : EXC_MUL;
    end
  end

  // Writes to r0 without exception carry no information and are dropped.
  assign done_keep = complete & (md_x | (inflight_rd_q != 5'd0));

`ifdef MULTDIV_WB_BYPASS_EN
  assign bypass_ok = done_keep;
`else
  assign bypass_ok = 1'b0;
`endif

  // Write-port priority: MW stage, then FIFO head, then optional bypass.
  always_comb begin
    rf_we    = 1'b0;
    rf_rd    = 5'd0;
    rf_data  = 32'd0;
    fifo_pop = 1'b0;
    bypass   = 1'b0;
    if (reset_n) begin
      if (mw_claim) begin
        rf_we   = 1'b1;
        rf_rd   = mw_rd;
        rf_data = mw_data;
      end else if (!fifo_empty) begin
        rf_we    = 1'b1;
        rf_rd    = fifo_head.rd;
        rf_data  = fifo_head.data;
        fifo_pop = 1'b1;
      end else if (bypass_ok) begin
        rf_we   = 1'b1;
        rf_rd   = done_entry.rd;
        rf_data = done_entry.data;
        bypass  = 1'b1;
      end
    end
  end

  assign fifo_push = done_keep & ~bypass;

  multdiv_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (fifo_push),
    .entry_i (done_entry),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .valid_o (fifo_valid),
    .rd_o    (fifo_rd)
  );

  assign issue_stall = inflight_valid_q | (fifo_count >= StallCount);

  // Registers still owed a mult/div writeback; r0 is never busy.
  always_comb begin
    busy_mask = 32'd0;
    if (inflight_valid_q) busy_mask[inflight_rd_q] = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i]) busy_mask[fifo_rd[i]] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

`ifndef SYNTHESIS
  start_while_inflight: assert property (@(posedge clock) disable iff (!reset_n)
    !(md_start && inflight_valid_q));
`endif

endmodule

// File: tb/tb_multdiv_wb_arbiter.sv
// Bench for multdiv_wb_arbiter: directed scenarios then random traffic, all
// checked each cycle against a queue-based reference model.
module tb_multdiv_wb_arbiter;

  localparam int unsigned DEPTH   = 2;
  localparam logic [4:0]  RSTATUS = 5'd30;
  localparam logic [4:0]  MUL     = 5'b00110;
  localparam logic [4:0]  DIV     = 5'b00111;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        md_start, md_ready, md_x, mw_we;
  logic [31:0] md_start_ir, md_res, mw_data;
  logic [4:0]  mw_rd;
  logic        rf_we, issue_stall;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data, busy_mask;

  multdiv_wb_arbiter #(
    .DEPTH       (DEPTH),
    .RSTATUS_REG (RSTATUS)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .md_start    (md_start),
    .md_start_ir (md_start_ir),
    .md_ready    (md_ready),
    .md_x        (md_x),
    .md_res      (md_res),
    .mw_we       (mw_we),
    .mw_rd       (mw_rd),
    .mw_data     (mw_data),
    .rf_we       (rf_we),
    .rf_rd       (rf_rd),
    .rf_data     (rf_data),
    .issue_stall (issue_stall),
    .busy_mask   (busy_mask)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;

  // Stimulus for the next cycle.
  logic        s_start, s_rdy, s_x, s_mwe;
  logic [31:0] s_ir, s_res, s_mdat;
  logic [4:0]  s_mrd;

  // Reference model state: one outstanding op plus an ordered result queue.
  logic        m_inf_v;
  logic [4:0]  m_inf_rd, m_inf_op;
  ent_t        q[$];

  // Observations of the last cycle.
  logic        o_we, o_stall;
  logic [4:0]  o_rd;
  logic [31:0] o_data, o_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc_n, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [4:0] rd);
    logic [31:0] ir;
    ir        = $urandom();
    ir[26:22] = rd;
    ir[6:2]   = op;
    return ir;
  endfunction

  task automatic clr();
    s_start = 1'b0; s_ir = 32'd0; s_rdy = 1'b0; s_x = 1'b0; s_res = 32'd0;
    s_mwe = 1'b0; s_mrd = 5'd0; s_mdat = 32'd0;
  endtask

  function automatic logic model_stall();
    return m_inf_v || (q.size() >= DEPTH - 1);
  endfunction

  // One clock cycle: drive, predict, sample mid-cycle, compare, advance model.
  task automatic cyc();
    logic        claim, comp, keep, pop, byp, e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_busy;
    ent_t        ent;
    md_start = s_start; md_start_ir = s_ir; md_ready = s_rdy; md_x = s_x;
    md_res = s_res; mw_we = s_mwe; mw_rd = s_mrd; mw_data = s_mdat;

    claim = s_mwe && (s_mrd != 5'd0);
    comp  = s_rdy && m_inf_v;
    if (s_x) begin
      ent.rd   = RSTATUS;
      ent.data = (m_inf_op == DIV) ? 32'd5 : 32'd4;
    end else begin
      ent.rd   = m_inf_rd;
      ent.data = s_res;
    end
    keep = comp && (s_x || m_inf_rd != 5'd0);
    pop = 1'b0; byp = 1'b0; e_we = 1'b0; e_rd = 5'd0; e_data = 32'd0;
    if (claim) begin
      e_we = 1'b1; e_rd = s_mrd; e_data = s_mdat;
    end else if (q.size() > 0) begin
      e_we = 1'b1; e_rd = q[0].rd; e_data = q[0].data; pop = 1'b1;
    end else begin
`ifdef MULTDIV_WB_BYPASS_EN
      if (keep) begin
        e_we = 1'b1; e_rd = ent.rd; e_data = ent.data; byp = 1'b1;
      end
`endif
    end
    e_busy = 32'd0;
    if (m_inf_v) e_busy = e_busy | (32'd1 << m_inf_rd);
    foreach (q[i]) e_busy = e_busy | (32'd1 << q[i].rd);
    e_busy[0] = 1'b0;

    #4;
    o_we = rf_we; o_rd = rf_rd; o_data = rf_data; o_stall = issue_stall; o_busy = busy_mask;
    chk("model_we", 32'(o_we), 32'(e_we));
    if (e_we) begin
      chk("model_rd", 32'(o_rd), 32'(e_rd));
      chk("model_data", o_data, e_data);
    end
    chk("model_stall", 32'(o_stall), 32'(model_stall()));
    chk("model_busy", o_busy, e_busy);

    @(posedge clock);
    if (pop) void'(q.pop_front());
    if (keep && !byp) q.push_back(ent);
    if (comp) m_inf_v = 1'b0;
    else if (s_start && !m_inf_v) begin
      m_inf_v = 1'b1; m_inf_rd = s_ir[26:22]; m_inf_op = s_ir[6:2];
    end
    cyc_n++;
    #1;
  endtask

  // Start, wait, complete; leaves the write-cycle observation in o_*.
  logic [31:0] w_busy;
  task automatic run_op(input logic [4:0] op, input logic [4:0] rd, input logic x,
                        input logic [31:0] res);
    clr(); s_start = 1'b1; s_ir = mk_ir(op, rd); cyc();
    clr(); cyc();
    w_busy = o_busy;
    clr(); s_rdy = 1'b1; s_x = x; s_res = res; cyc();
`ifndef MULTDIV_WB_BYPASS_EN
    clr(); cyc();
`endif
  endtask

  task automatic mw_hold();
    clr(); s_mwe = 1'b1; s_mrd = 5'd9; s_mdat = 32'hAA;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    m_inf_v = 1'b0; m_inf_rd = 5'd0; m_inf_op = 5'd0;
    clr();
    md_start = 1'b0; md_start_ir = 32'd0; md_ready = 1'b0; md_x = 1'b0;
    md_res = 32'd0; mw_we = 1'b0; mw_rd = 5'd0; mw_data = 32'd0;
    reset_n = 1'b0;
    #12;
    chk("reset_we", 32'(rf_we), 32'd0);
    chk("reset_rd", 32'(rf_rd), 32'd0);
    chk("reset_data", rf_data, 32'd0);
    chk("reset_stall", 32'(issue_stall), 32'd0);
    chk("reset_busy", busy_mask, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // MUL r5 = 42.
    run_op(MUL, 5'd5, 1'b0, 32'd42);
    chk("mul_busy5", 32'(w_busy[5]), 32'd1);
    chk("mul_we", 32'(o_we), 32'd1);
    chk("mul_rd", 32'(o_rd), 32'd5);
    chk("mul_data", o_data, 32'd42);

    // Exceptions redirect to the status register with the op's code.
    run_op(DIV, 5'd7, 1'b1, 32'h99);
    chk("divx_rd", 32'(o_rd), 32'd30);
    chk("divx_data", o_data, 32'd5);
    run_op(MUL, 5'd12, 1'b1, 32'h77);
    chk("mulx_rd", 32'(o_rd), 32'd30);
    chk("mulx_data", o_data, 32'd4);
    clr(); cyc();

    // MUL r3 completes while MW owns the port for 4 cycles.
    clr(); s_start = 1'b1; s_ir = mk_ir(MUL, 5'd3); cyc();
    clr(); cyc();
    mw_hold(); s_rdy = 1'b1; s_res = 32'h33; cyc();
    chk("mwhold_rd", 32'(o_rd), 32'd9);
    for (int i = 0; i < 3; i++) begin
      mw_hold(); cyc();
      chk("mwhold_rd", 32'(o_rd), 32'd9);
      chk("mwhold_data", o_data, 32'hAA);
      chk("mwhold_stall", 32'(o_stall), 32'd1);
    end
    clr(); cyc();
    chk("drain_rd", 32'(o_rd), 32'd3);
    chk("drain_data", o_data, 32'h33);
    clr(); cyc();

    // rd = 0 without exception writes nothing.
    clr(); s_start = 1'b1; s_ir = mk_ir(MUL, 5'd0); cyc();
    clr(); cyc();
    chk("r0_busy", o_busy, 32'd0);
    clr(); s_rdy = 1'b1; s_res = 32'd123; cyc();
    chk("r0_we_rdy", 32'(o_we), 32'd0);
    clr(); cyc();
    chk("r0_we_next", 32'(o_we), 32'd0);

    // Reset with one op in flight and one entry buffered.
    clr(); s_start = 1'b1; s_ir = mk_ir(MUL, 5'd6); cyc();
    clr(); cyc();
    mw_hold(); s_rdy = 1'b1; s_res = 32'h66; cyc();
    mw_hold(); s_start = 1'b1; s_ir = mk_ir(MUL, 5'd8); cyc();
    mw_hold(); cyc();
    chk("prerst_busy", o_busy, (32'd1 << 6) | (32'd1 << 8));
    mw_we = 1'b1; mw_rd = 5'd9; mw_data = 32'hAA;
    reset_n = 1'b0;
    #1;
    chk("midrst_we", 32'(rf_we), 32'd0);
    chk("midrst_rd", 32'(rf_rd), 32'd0);
    chk("midrst_data", rf_data, 32'd0);
    chk("midrst_stall", 32'(issue_stall), 32'd0);
    chk("midrst_busy", busy_mask, 32'd0);
    m_inf_v = 1'b0; q.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    clr(); s_rdy = 1'b1; s_res = 32'h88; cyc();
    chk("postrst_we", 32'(o_we), 32'd0);
    clr(); cyc();
    chk("postrst_we2", 32'(o_we), 32'd0);

    // Back-to-back ops held off by MW; second issue waits for the drain.
    clr(); s_start = 1'b1; s_ir = mk_ir(MUL, 5'd10); cyc();
    clr(); cyc();
    mw_hold(); s_rdy = 1'b1; s_res = 32'h1010; cyc();
    for (int i = 0; i < 2; i++) begin
      mw_hold(); cyc();
      chk("b2b_stall", 32'(o_stall), 32'd1);
    end
    clr(); cyc();
    chk("b2b_first_rd", 32'(o_rd), 32'd10);
    for (int i = 0; i < 8 && o_stall; i++) begin
      clr(); cyc();
    end
    chk("b2b_unstall", 32'(o_stall), 32'd0);
    clr(); s_start = 1'b1; s_ir = mk_ir(DIV, 5'd11); cyc();
    clr(); cyc();
    mw_hold(); s_rdy = 1'b1; s_res = 32'h1111; cyc();
    mw_hold(); cyc();
    clr(); cyc();
    chk("b2b_second_rd", 32'(o_rd), 32'd11);
    chk("b2b_second_data", o_data, 32'h1111);

    // Random traffic obeying the issue protocol.
    for (int i = 0; i < 1500; i++) begin
      clr();
      if (!model_stall() && $urandom_range(0, 2) == 0) begin
        s_start = 1'b1;
        s_ir = mk_ir(($urandom_range(0, 1) == 0) ? MUL : DIV,
                     ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
      end
      if (m_inf_v) s_rdy = ($urandom_range(0, 3) == 0);
      else         s_rdy = ($urandom_range(0, 15) == 0);
      s_x   = ($urandom_range(0, 4) == 0);
      s_res = $urandom();
      s_mwe = ($urandom_range(0, 2) == 0);
      s_mrd = 5'($urandom_range(0, 31));
      s_mdat = $urandom();
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
